// File: rtl/lsu_seq.sv
// -----------------------------------------------------------------------------
// lsu_seq - load/store sequencer between the execute stage and a data memory
// port that may insert wait states.
//
// Accepts one load or store per core handshake, drives a word-aligned DMEM
// request with byte enables and lane-replicated store data, slices and extends
// load data for writeback, and reports misaligned / illegal-width / timeout
// faults. The core stalls while busy is high and retires on done.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   req_valid/ready   core request handshake (ready only in IDLE)
//   req_store         1 = store, 0 = load
//   req_funct3        access width/sign (B, H, W, BU, HU)
//   req_addr          effective address
//   req_wdata         store data
//   req_rd            load destination register
//   mem_valid/ready   DMEM request handshake
//   mem_addr          word-aligned address
//   mem_dwe           byte write enables (zero for loads and outside REQ)
//   mem_wdata         lane-replicated store data
//   mem_rdata         load data, valid with mem_ready
//   wb_valid/rd/data  one-cycle register writeback
//   done              one-cycle retire pulse (success or fault)
//   err_valid/cause   one-cycle fault pulse: 01 misaligned, 10 illegal, 11 timeout
//   busy              sequencer not idle
//   state_dbg         current FSM state (IDLE=0, REQ=1, DONE=2, ERR=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_valid is only looked at while req_ready is high (IDLE);
// mem_ready is only looked at while mem_valid is high (REQ), and mem_valid
// with its address/enables/data stays stable until that transfer or timeout.
// -----------------------------------------------------------------------------
module lsu_seq #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_dwe,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err_valid,
    output logic [1:0]  err_cause,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    state_t      state;
    state_t      state_next;

    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [7:0]  wait_cnt;
    logic [1:0]  cause_q;
    logic [31:0] wb_data_q;

    logic        illegal;
    logic        misaligned;
    logic        last_wait;
    logic [31:0] rdata_shift;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [3:0]  store_dwe;
    logic [31:0] store_lanes;

    // ---------------------------------------------------------------------
    // Request classification, evaluated on the live request in IDLE.
    // ---------------------------------------------------------------------
    always_comb begin
        if (req_store) begin
            // Only SB/SH/SW exist for stores.
            illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                      (req_funct3 == 3'b111);
        end
        // funct3[1:0] carries the width for both signed and unsigned forms.
        misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                     ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    assign last_wait = (wait_cnt == LAST_WAIT);

    // ---------------------------------------------------------------------
    // Load slicing and extension from the latched address/width.
    // ---------------------------------------------------------------------
    always_comb begin
        rdata_shift = mem_rdata >> {addr_q[1:0], 3'b000};
        load_byte   = rdata_shift[7:0];
        load_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {24'd0, load_byte};
            3'b101:  load_ext = {16'd0, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // ---------------------------------------------------------------------
    // Store lane placement from the latched address/width.
    // ---------------------------------------------------------------------
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                store_dwe   = 4'b0001 << addr_q[1:0];
                store_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_dwe   = addr_q[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                store_dwe   = 4'b1111;
                store_lanes = wdata_q;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM state register.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and control outputs.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        done       = 1'b0;
        err_valid  = 1'b0;
        wb_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (illegal || misaligned) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_valid = 1'b1;
                // A completion in the last allowed cycle beats the timeout.
                if (mem_ready) begin
                    state_next = S_DONE;
                end else if (last_wait) begin
                    state_next = S_ERR;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                wb_valid   = ~store_q & (rd_q != 5'd0);
                state_next = S_IDLE;
            end
            S_ERR: begin
                done       = 1'b1;
                err_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Request latches, wait counter, fault cause and load capture.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            store_q   <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rd_q      <= 5'd0;
            wait_cnt  <= 8'd0;
            cause_q   <= 2'b00;
            wb_data_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rd_q     <= req_rd;
                        wait_cnt <= 8'd0;
                        // Only consumed if this request faults; illegal wins.
                        cause_q  <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        if (!store_q) begin
                            wb_data_q <= load_ext;
                        end
                    end else if (last_wait) begin
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Datapath outputs.
    // ---------------------------------------------------------------------
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_dwe   = ((state == S_REQ) && store_q) ? store_dwe : 4'b0000;
    assign mem_wdata = store_lanes;
    assign wb_rd     = rd_q;
    assign wb_data   = wb_data_q;
    assign err_cause = (state == S_ERR) ? cause_q : 2'b00;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_lsu_seq.sv
module tb_lsu_seq;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_dwe;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        err_valid;
  logic [1:0]  err_cause;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_q[$];

  lsu_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_dwe    (mem_dwe),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .done       (done),
    .err_valid  (err_valid),
    .err_cause  (err_cause),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // One transaction, issued at the current negedge while the DUT is idle.
  // Expectations come from the access rules (width, alignment, wait count).
  task automatic run_txn(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdata, input int lat);
    int size, a, exp_nv, nv, done_c, wb_n, err_n;
    bit legal, exp_wb;
    logic [1:0]  exp_cause;
    logic [3:0]  exp_dwe;
    logic [31:0] exp_wdata, exp_addr, v, e;

    size = 1 << (f3 % 4);
    a = int'(addr % 4);
    legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    if (!legal) exp_cause = 2'd2;
    else if ((addr % size) != 0) exp_cause = 2'd1;
    else if (lat >= TIMEOUT) exp_cause = 2'd3;
    else exp_cause = 2'd0;
    if (exp_cause == 2'd1 || exp_cause == 2'd2) exp_nv = 0;
    else if (exp_cause == 2'd3) exp_nv = TIMEOUT;
    else exp_nv = lat + 1;
    exp_wb = !st && exp_cause == 2'd0 && rd != 5'd0;
    if (size == 1) begin
      v = (rdata >> (8 * a)) & 32'hFF;
      if (f3 < 3'd4 && v >= 32'd128) v = v - 32'd256;
      exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
    end else if (size == 2) begin
      v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
      if (f3 < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
      exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      v = rdata;
      exp_wdata = wd;
    end
    exp_dwe = st ? 4'(((1 << size) - 1) << a) : 4'd0;
    exp_addr = addr & 32'hFFFF_FFFC;
    if (exp_wb) exp_q.push_back(v);

    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    nv = 0; done_c = 0; wb_n = 0; err_n = 0;
    for (int c = 1; c <= 400 && done_c == 0; c++) begin
      @(negedge clk);
      // request fields are ignored once accepted
      req_valid = 1'b0; req_store = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7)); req_addr = $urandom;
      req_wdata = $urandom; req_rd = 5'($urandom_range(0, 31));
      n_cmp++;
      if (mem_dwe !== (mem_valid ? exp_dwe : 4'd0)) begin
        n_bad++;
        $display("FAIL %s dwe c=%0d: got %b want %b", name, c, mem_dwe, mem_valid ? exp_dwe : 4'd0);
      end
      if (mem_valid) begin
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_bad++;
          $display("FAIL %s mem_addr c=%0d: got %h want %h", name, c, mem_addr, exp_addr);
        end
        if (st) begin
          n_cmp++;
          if (mem_wdata !== exp_wdata) begin
            n_bad++;
            $display("FAIL %s mem_wdata c=%0d: got %h want %h", name, c, mem_wdata, exp_wdata);
          end
        end
        if (nv == lat) begin
          mem_ready = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom;
        end
        nv++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (wb_valid) begin
        wb_n++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s wb_unexpected: got wb_valid=1 want 0", name);
        end else begin
          e = exp_q.pop_front();
          if (wb_data !== e || wb_rd !== rd || done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s wb: got data=%h rd=%0d done=%b want data=%h rd=%0d done=1",
                     name, wb_data, wb_rd, done, e, rd);
          end
        end
      end
      if (err_valid) begin
        err_n++;
        n_cmp++;
        if (err_cause !== exp_cause || done !== 1'b1) begin
          n_bad++;
          $display("FAIL %s err: got cause=%b done=%b want cause=%b done=1",
                   name, err_cause, done, exp_cause);
        end
      end
      if (done) done_c = c;
    end
    n_cmp++;
    if (done_c != exp_nv + 1) begin
      n_bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_c, exp_nv + 1);
    end
    n_cmp++;
    if (nv != exp_nv) begin
      n_bad++;
      $display("FAIL %s mem_valid_cycles: got %0d want %0d", name, nv, exp_nv);
    end
    n_cmp++;
    if (wb_n != int'(exp_wb)) begin
      n_bad++;
      $display("FAIL %s wb_count: got %0d want %0d", name, wb_n, int'(exp_wb));
    end
    n_cmp++;
    if (err_n != int'(exp_cause != 2'd0)) begin
      n_bad++;
      $display("FAIL %s err_count: got %0d want %0d", name, err_n, int'(exp_cause != 2'd0));
    end
    exp_q.delete();
    @(negedge clk);
    mem_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_after: got ready=%b busy=%b done=%b want 1 0 0",
               name, req_ready, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, mem_valid, mem_addr, mem_dwe, mem_wdata, wb_valid, wb_rd, wb_data,
         done, err_valid, err_cause, busy} !== {1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0,
         5'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b mv=%b addr=%h dwe=%b wd=%h wbv=%b rd=%0d wbd=%h done=%b ev=%b ec=%b busy=%b want all 0 except ready=1",
               req_ready, mem_valid, mem_addr, mem_dwe, mem_wdata, wb_valid, wb_rd,
               wb_data, done, err_valid, err_cause, busy);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_txn("lb_0x103", 1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 32'h80AA_BBCC, 0);
    run_txn("lbu_0x103", 1'b0, 3'b100, 32'h103, 32'h0, 5'd6, 32'h80AA_BBCC, 0);
    run_txn("sh_0x0a", 1'b1, 3'b001, 32'h0A, 32'h1234_5678, 5'd3, 32'h0, 3);
    run_txn("sw_misaligned", 1'b1, 3'b010, 32'h06, 32'hCAFE_F00D, 5'd0, 32'h0, 0);
    run_txn("store_f3_011", 1'b1, 3'b011, 32'h08, 32'h1, 5'd0, 32'h0, 0);
    run_txn("load_f3_110_misal", 1'b0, 3'b110, 32'h03, 32'h0, 5'd9, 32'h0, 0);
    run_txn("lw_timeout", 1'b0, 3'b010, 32'h200, 32'h0, 5'd4, 32'h1111_2222, TIMEOUT);
    run_txn("lw_last_cycle", 1'b0, 3'b010, 32'h204, 32'h0, 5'd4, 32'h3333_4444, TIMEOUT - 1);
    run_txn("lw_rd0", 1'b0, 3'b010, 32'h208, 32'h0, 5'd0, 32'h5555_6666, 1);
    run_txn("lh_hi", 1'b0, 3'b001, 32'h32, 32'h0, 5'd8, 32'h9ABC_1234, 2);
    run_txn("lhu_hi", 1'b0, 3'b101, 32'h32, 32'h0, 5'd8, 32'h9ABC_1234, 0);
    run_txn("sb_lane2", 1'b1, 3'b000, 32'h46, 32'hA5A5_A5E7, 5'd1, 32'h0, 0);
  endtask

  task automatic test_mid_reset();
    int nv;
    nv = 0;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'h0; req_rd = 5'd7;
    @(posedge clk);
    for (int c = 0; c < 50 && nv < 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ready = 1'b0;
      if (mem_valid) nv++;
    end
    n_cmp++;
    if (nv != 3) begin
      n_bad++;
      $display("FAIL mid_reset_reach_req: got %0d valid cycles want 3", nv);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({mem_valid, busy, req_ready, done, wb_valid, mem_addr} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got mv=%b busy=%b ready=%b done=%b wbv=%b addr=%h want 0 0 1 0 0 0",
               mem_valid, busy, req_ready, done, wb_valid, mem_addr);
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || wb_valid !== 1'b0 || mem_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_reset_late_ready c=%0d: got done=%b wbv=%b mv=%b want 0 0 0",
                 c, done, wb_valid, mem_valid);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int lat;
    for (int i = 0; i < 40; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      case ($urandom_range(0, 5))
        0: lat = TIMEOUT - 1;
        1: lat = TIMEOUT;
        default: lat = $urandom_range(0, 3);
      endcase
      run_txn("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr,
              $urandom, 5'($urandom_range(0, 31)), $urandom, lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_mid_reset();
    @(negedge clk);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Load/store sequencer between the RISC-V core's execute stage and a data memory port that may insert wait states. It accepts one load or store per handshake from the core (effective address from the ALU, store data from rv2) and drives the DMEM request with word-aligned address, per-byte write enables and lane-replicated write data. It slices and extends load data for register writeback, and reports misaligned, illegal-width and timeout faults. The core holds its PC while `busy` is high and retires the memory instruction on `done`.

## Interface
- `TIMEOUT`, 16, maximum number of cycles `mem_valid` stays high without `mem_ready` (legal range 1..255)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset
- `req_valid`  in  1  core presents a memory instruction
- `req_ready`  out  1  sequencer can accept (high only in IDLE)
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  32  effective address (rv1+imm)
- `req_wdata`  in  32  store data (rv2)
- `req_rd`  in  5  load destination register
- `mem_valid`  out  1  DMEM request active
- `mem_ready`  in  1  DMEM completes request this cycle
- `mem_addr`  out  32  {req_addr[31:2], 2'b00}
- `mem_dwe`  out  4  byte write enables (0000 for loads)
- `mem_wdata`  out  32  lane-replicated store data
- `mem_rdata`  in  32  load data, valid when `mem_ready`=1
- `wb_valid`  out  1  one-cycle regfile write strobe
- `wb_rd`  out  5  writeback register
- `wb_data`  out  32  extended load value
- `done`  out  1  one-cycle retire pulse (success or fault)
- `err_valid`  out  1  one-cycle fault pulse, coincident with `done`
- `err_cause`  out  2  01 misaligned, 10 illegal funct3, 11 timeout
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE: `req_ready`=1. On `req_valid`=1, latch store, funct3, addr, wdata and rd, then classify:
  - Illegal: load funct3 ∈ {011,110,111}; store funct3 > 010. Go to ERR with cause 10.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00. Go to ERR with cause 01. Illegal takes priority over misaligned.
  - Otherwise go to REQ and clear the wait counter.
- REQ: `mem_valid`=1, and `mem_addr`/`mem_dwe`/`mem_wdata` are held stable.
  - On `mem_ready`=1: capture `mem_rdata` for a load, then go to DONE.
  - Otherwise, if wait counter = TIMEOUT-1, go to ERR with cause 11. Otherwise increment the counter.
  - `mem_ready` in the final allowed cycle wins over the timeout.
- DONE: `done`=1. For a load with rd≠0: `wb_valid`=1 and `wb_rd`=latched rd. Next state is IDLE.
- ERR: `done`=1, `err_valid`=1, `err_cause` set. No memory access and no writeback. Next state is IDLE.
- Store lanes (a = addr[1:0]):
  - SB: `mem_dwe` = 0001 << a, `mem_wdata` = {4{wdata[7:0]}}.
  - SH: `mem_dwe` = 0011 (a=00) or 1100 (a=10), `mem_wdata` = {2{wdata[15:0]}}.
  - SW: `mem_dwe` = 1111, `mem_wdata` = wdata.
- Load slicing: byte at rdata[8a+7:8a]; half at rdata[16a[1]+15:16a[1]]. B/H sign-extend, BU/HU zero-extend, W passes through.
- `mem_dwe` is 0000 outside REQ and for all loads.
- `wb_data` is held from capture until the next capture. `wb_rd` is held until the next accept.

## Timing
- Reset low at an edge: state goes to IDLE, wait counter clears, and from the next cycle all outputs are 0 except `req_ready`=1. This applies mid-transaction too: `mem_valid` drops and any later `mem_ready`/`mem_rdata` is ignored.
- Accept at edge t. REQ spans t+1 … handshake edge h. DONE is the cycle after h. IDLE (`req_ready`=1) follows.
- Zero-wait access: `mem_valid` high for 1 cycle, `done` in cycle t+2, next accept at edge t+3. Throughput is one access per 3 cycles.
- Fault at accept: ERR in cycle t+1, next accept at edge t+2.
- Timeout: `mem_valid` high for exactly TIMEOUT cycles, then ERR for one cycle.
- `mem_ready` is ignored outside REQ. `req_valid` is ignored outside IDLE. The core drops `req_valid` after acceptance.

## Test plan
- LB, addr 0x103, `mem_rdata` 0x80AA_BBCC, `mem_ready` at first REQ cycle → `mem_addr` 0x100, `mem_dwe` 0000; `wb_data` 0xFFFF_FF80 with `wb_valid`/`done` in cycle t+2; LBU at same address gives 0x0000_0080.
- SH, addr 0x0A, wdata 0x1234_5678, `mem_ready` after 3 wait cycles → `mem_dwe` 1100, `mem_wdata` 0x5678_5678, `mem_valid` high for 4 cycles, `done` once, no `wb_valid`.
- SW, addr 0x06 → ERR cause 01 at t+1, `mem_valid` never asserted; store funct3=011 → cause 10.
- LW, TIMEOUT=16, `mem_ready` held 0 → `mem_valid` high exactly 16 cycles, then `err_valid` with cause 11; repeat with `mem_ready` in the 16th cycle → normal `done`, no error.
- LW with rd=0 → `done` pulses, `wb_valid` stays 0.
- Reset low during REQ (wait state 2) → next cycle `mem_valid`=0, `busy`=0, `req_ready`=1; late `mem_ready` produces no `done`/`wb_valid`.
